// File: rtl/rcv_pkg.sv
// Shared types and constants for the serial receive controller.
package rcv_pkg;

    localparam int unsigned BIT_CLKS_DEFAULT = 10;
    localparam int unsigned CNT_BITS         = 4;
    localparam logic [7:0]  ERR_COUNT_MAX    = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StStartChk,
        StReceive,
        StStopLatch,
        StStopEval,
        StLoad
    } rcv_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == ERR_COUNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Wrapping counter 0..rollover_val-1; rollover_flag marks the final count while enabled.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    assign rollover_flag = count_enable && (count_q == rollover_val - ONE);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = rollover_flag ? '0 : count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rcv_ctrl.sv
// Receive-side frame controller: start-bit qualification, frame timing handoff,
// stop-bit evaluation and sticky error bookkeeping.
module rcv_ctrl
    import rcv_pkg::*;
#(
    parameter int unsigned BIT_CLKS = BIT_CLKS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_bit_detected,
    input  logic       rx_sync,
    input  logic       packet_done,
    input  logic       stop_bit_err,
    input  logic       clear_errors,
    output logic       sbc_clear,
    output logic       sbc_enable,
    output logic       enable_timer,
    output logic       load_buffer,
    output logic       rx_busy,
    output logic       framing_error,
    output logic       false_start,
    output logic [7:0] err_count
);

    localparam logic [CNT_BITS-1:0] HALF_BIT = CNT_BITS'(BIT_CLKS / 2);

    rcv_state_t state_q, state_d;
    logic       half_last;
    logic       fs_evt, fe_evt;
    logic       framing_error_q, framing_error_d;
    logic       false_start_q, false_start_d;
    logic [7:0] err_count_q, err_count_d;

    flex_counter #(
        .NUM_CNT_BITS (CNT_BITS)
    ) u_half_bit (
        .clk           (clk),
        .rst           (rst),
        .clear         (state_q != StStartChk),
        .count_enable  (state_q == StStartChk),
        .rollover_val  (HALF_BIT),
        .rollover_flag (half_last)
    );

    always_comb begin
        state_d = state_q;
        fs_evt  = 1'b0;
        fe_evt  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_bit_detected) state_d = StStartChk;
            end
            StStartChk: begin
                // Line must still be low at mid start bit, otherwise it was a glitch.
                if (half_last) begin
                    if (rx_sync) begin
                        state_d = StIdle;
                        fs_evt  = 1'b1;
                    end else begin
                        state_d = StReceive;
                    end
                end
            end
            StReceive: begin
                if (packet_done) state_d = StStopLatch;
            end
            StStopLatch: state_d = StStopEval;
            StStopEval: begin
                if (stop_bit_err) begin
                    state_d = StIdle;
                    fe_evt  = 1'b1;
                end else begin
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A new error in the same cycle as clear_errors survives the clear.
    always_comb begin
        if (clear_errors) begin
            false_start_d   = fs_evt;
            framing_error_d = fe_evt;
            err_count_d     = (fs_evt || fe_evt) ? 8'd1 : 8'd0;
        end else begin
            false_start_d   = false_start_q | fs_evt;
            framing_error_d = framing_error_q | fe_evt;
            err_count_d     = (fs_evt || fe_evt) ? sat_inc(err_count_q) : err_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            false_start_q   <= 1'b0;
            framing_error_q <= 1'b0;
            err_count_q     <= 8'd0;
        end else begin
            state_q         <= state_d;
            false_start_q   <= false_start_d;
            framing_error_q <= framing_error_d;
            err_count_q     <= err_count_d;
        end
    end

    always_comb begin
        sbc_clear     = (state_q == StStartChk);
        sbc_enable    = (state_q == StStopLatch);
        enable_timer  = (state_q == StReceive);
        load_buffer   = (state_q == StLoad);
        rx_busy       = (state_q != StIdle);
        false_start   = false_start_q;
        framing_error = framing_error_q;
        err_count     = err_count_q;
    end

endmodule

// File: tb/tb_rcv_ctrl.sv
// Self-checking bench for rcv_ctrl with BIT_CLKS=10; load_buffer pulses are scoreboarded.
module tb_rcv_ctrl;

    localparam int unsigned BIT_CLKS = 10;

    logic       clk;
    logic       rst;
    logic       start_bit_detected;
    logic       rx_sync;
    logic       packet_done;
    logic       stop_bit_err;
    logic       clear_errors;
    logic       sbc_clear;
    logic       sbc_enable;
    logic       enable_timer;
    logic       load_buffer;
    logic       rx_busy;
    logic       framing_error;
    logic       false_start;
    logic [7:0] err_count;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int exp_err = 0;
    bit exp_fs  = 1'b0;
    bit exp_fe  = 1'b0;
    int load_q[$];
    int mon_exp;

    rcv_ctrl #(
        .BIT_CLKS (BIT_CLKS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start_bit_detected (start_bit_detected),
        .rx_sync            (rx_sync),
        .packet_done        (packet_done),
        .stop_bit_err       (stop_bit_err),
        .clear_errors       (clear_errors),
        .sbc_clear          (sbc_clear),
        .sbc_enable         (sbc_enable),
        .enable_timer       (enable_timer),
        .load_buffer        (load_buffer),
        .rx_busy            (rx_busy),
        .framing_error      (framing_error),
        .false_start        (false_start),
        .err_count          (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every load_buffer pulse must match the next scheduled cycle in the scoreboard.
    always @(negedge clk) begin
        if (load_buffer !== 1'b0) begin
            checks++;
            if (load_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected: load_buffer=%b at cycle %0d, required 0",
                         load_buffer, cyc);
            end else begin
                mon_exp = load_q.pop_front();
                if (cyc != mon_exp) begin
                    errors++;
                    $display("FAIL load_timing: load_buffer pulse at cycle %0d, required %0d",
                             cyc, mon_exp);
                end
            end
        end
    end

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start_bit_detected = 1'b0;
        rx_sync            = 1'b1;
        packet_done        = 1'b0;
        stop_bit_err       = 1'b0;
        clear_errors       = 1'b0;
    endtask

    task automatic check_flags(input string name);
        checks++;
        if ({false_start, framing_error, err_count} !== {exp_fs, exp_fe, 8'(exp_err)}) begin
            errors++;
            $display("FAIL %s: fs/fe/count=%b/%b/%0d, required %b/%b/%0d", name,
                     false_start, framing_error, err_count, exp_fs, exp_fe, exp_err);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({sbc_clear, sbc_enable, enable_timer, load_buffer, rx_busy, framing_error,
             false_start, err_count} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: outputs=%b, required all 0",
                     {sbc_clear, sbc_enable, enable_timer, load_buffer, rx_busy,
                      framing_error, false_start, err_count});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rx_busy=%b, required 0", rx_busy);
        end
    endtask

    // Full frame: start at cycle 0, packet_done at 97, stop check at 99, load at 100.
    task automatic run_frame(input bit bad_stop, input bit stray_start);
        logic [3:0] exp_v;
        start_bit_detected = 1'b1;
        rx_sync            = 1'b0;
        if (!bad_stop) load_q.push_back(cyc + 100);
        for (int c = 1; c <= 100; c++) begin
            tick();
            start_bit_detected = stray_start && (c == 20);
            rx_sync            = (c <= 5) ? 1'b0 : 1'($urandom_range(0, 1));
            packet_done        = (c == 97);
            stop_bit_err       = bad_stop && (c == 99);
            exp_v = {(c >= 6 && c <= 97), (c <= 5), (c == 98),
                     bad_stop ? (c <= 99) : (c <= 100)};
            checks++;
            if ({enable_timer, sbc_clear, sbc_enable, rx_busy} !== exp_v) begin
                errors++;
                $display("FAIL frame_strobes c%0d: timer/clr/en/busy=%b, required %b", c,
                         {enable_timer, sbc_clear, sbc_enable, rx_busy}, exp_v);
            end
        end
        idle_inputs();
        if (bad_stop) begin
            exp_fe  = 1'b1;
            exp_err = sat_inc(exp_err);
        end
        check_flags(bad_stop ? "framing_flags" : "frame_flags");
        tick();
    endtask

    task automatic test_valid_frame;
        run_frame(1'b0, 1'b0);
    endtask

    task automatic test_framing_error;
        run_frame(1'b1, 1'b0);
    endtask

    task automatic test_ignored_start;
        run_frame(1'b0, 1'b1);
    endtask

    task automatic test_false_start(input bit with_clear);
        logic [2:0] exp_v;
        start_bit_detected = 1'b1;
        rx_sync            = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start_bit_detected = 1'b0;
            clear_errors       = with_clear && (c == 5);
            exp_v = {1'b0, (c <= 5), (c <= 5)};
            checks++;
            if ({enable_timer, sbc_clear, rx_busy} !== exp_v) begin
                errors++;
                $display("FAIL false_start_strobes c%0d: timer/clr/busy=%b, required %b", c,
                         {enable_timer, sbc_clear, rx_busy}, exp_v);
            end
        end
        clear_errors = 1'b0;
        exp_fs = 1'b1;
        if (with_clear) begin
            exp_fe  = 1'b0;
            exp_err = 1;
        end else begin
            exp_err = sat_inc(exp_err);
        end
        check_flags(with_clear ? "clear_vs_error" : "false_start_flags");
    endtask

    task automatic test_reset_mid_frame;
        start_bit_detected = 1'b1;
        rx_sync            = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            start_bit_detected = 1'b0;
        end
        checks++;
        if (enable_timer !== 1'b1) begin
            errors++;
            $display("FAIL midframe_receive: enable_timer=%b, required 1", enable_timer);
        end
        rst = 1'b1;
        packet_done = 1'b1;
        tick();
        rst = 1'b0;
        exp_fs = 1'b0;
        exp_fe = 1'b0;
        exp_err = 0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({sbc_clear, sbc_enable, enable_timer, load_buffer, rx_busy, framing_error,
                 false_start, err_count} !== 15'd0) begin
                errors++;
                $display("FAIL midframe_reset c%0d: outputs=%b, required all 0", c,
                         {sbc_clear, sbc_enable, enable_timer, load_buffer, rx_busy,
                          framing_error, false_start, err_count});
            end
            packet_done = (c == 0);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_saturation_and_clear;
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        exp_fs  = 1'b0;
        exp_fe  = 1'b0;
        exp_err = 0;
        check_flags("clear_errors");
        for (int i = 0; i < 260; i++) test_false_start(1'b0);
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation: err_count=%0d, required 255", err_count);
        end
        test_false_start(1'b1);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_valid_frame();
        test_false_start(1'b0);
        test_framing_error();
        test_ignored_start();
        test_reset_mid_frame();
        test_saturation_and_clear();
        tick();
        checks++;
        if (load_q.size() != 0) begin
            errors++;
            $display("FAIL load_missing: %0d scheduled load pulses not seen, required 0",
                     load_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
